// File: rtl/rmt_ipv4_udp_parser.sv
// IPv4/UDP header parser: forwards the AXI-Stream unchanged through a 2-entry
// skid buffer and extracts header fields from each frame's first beat into a metadata slot.
module rmt_ipv4_udp_parser #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  m_hdr_valid,
    input  logic                  m_hdr_ready,
    output logic [31:0]           m_hdr_src_ip,
    output logic [31:0]           m_hdr_dst_ip,
    output logic [7:0]            m_hdr_protocol,
    output logic [15:0]           m_hdr_src_port,
    output logic [15:0]           m_hdr_dst_port,
    output logic                  m_hdr_is_udp,
    output logic                  m_hdr_error,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_errors
);

    localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

    typedef enum logic {
        ST_HEAD = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    function automatic logic [15:0] be16(input logic [DATA_WIDTH-1:0] d, input int k);
        return {d[8*k +: 8], d[8*(k+1) +: 8]};
    endfunction

    function automatic logic [31:0] be32(input logic [DATA_WIDTH-1:0] d, input int k);
        return {be16(d, k), be16(d, k + 2)};
    endfunction

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [2];
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            rdy_en_q;

    logic            hdr_valid_q, hdr_valid_d;
    logic [31:0]     src_ip_q, src_ip_d;
    logic [31:0]     dst_ip_q, dst_ip_d;
    logic [7:0]      proto_q, proto_d;
    logic [15:0]     src_port_q, src_port_d;
    logic [15:0]     dst_port_q, dst_port_d;
    logic            is_udp_q, is_udp_d;
    logic            error_q, error_d;
    logic [31:0]     frames_q, frames_d;
    logic [31:0]     errors_q, errors_d;

    logic            push_s, pop_s, hdr_load_s, hdr_drain_s;
    logic [EW-1:0]   in_beat_s;

    logic            p_trunc_s, p_frag_s, p_ihl_ok_s, p_ver_ok_s, p_udp_s, p_err_s;
    logic [31:0]     p_src_ip_s, p_dst_ip_s;
    logic [7:0]      p_proto_s;
    logic [15:0]     p_src_port_s, p_dst_port_s;

    // Handshake qualifiers and input acceptance
    always_comb begin
        s_axis_tready = rdy_en_q && (cnt_q != 2'd2) &&
                        ((state_q == ST_BODY) || !hdr_valid_q || m_hdr_ready);
        push_s        = s_axis_tvalid && s_axis_tready;
        pop_s         = m_axis_tvalid && m_axis_tready;
        hdr_load_s    = push_s && (state_q == ST_HEAD);
        hdr_drain_s   = hdr_valid_q && m_hdr_ready;
        in_beat_s     = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
    end

    // Header field extraction from the current input beat
    always_comb begin
        p_trunc_s    = ~(&s_axis_tkeep[37:0]);
        p_ver_ok_s   = (s_axis_tdata[8*14+4 +: 4] == 4'd4);
        p_ihl_ok_s   = (s_axis_tdata[8*14 +: 4] == 4'd5);
        p_frag_s     = s_axis_tdata[8*20+5] || (be16(s_axis_tdata, 20) & 16'h1FFF) != 16'h0000;
        p_src_ip_s   = 32'h0000_0000;
        p_dst_ip_s   = 32'h0000_0000;
        p_proto_s    = 8'h00;
        p_src_port_s = 16'h0000;
        p_dst_port_s = 16'h0000;
        p_udp_s      = 1'b0;
        p_err_s      = 1'b1;
        if (p_trunc_s) begin
            p_err_s = 1'b1;
        end else begin
            p_proto_s  = s_axis_tdata[8*23 +: 8];
            p_src_ip_s = be32(s_axis_tdata, 26);
            p_dst_ip_s = be32(s_axis_tdata, 30);
            p_err_s    = !p_ver_ok_s || !p_ihl_ok_s;
            p_udp_s    = (p_proto_s == 8'd17) && p_ihl_ok_s && !p_frag_s;
            if (p_udp_s) begin
                p_src_port_s = be16(s_axis_tdata, 34);
                p_dst_port_s = be16(s_axis_tdata, 36);
            end else begin
                p_src_port_s = 16'h0000;
                p_dst_port_s = 16'h0000;
            end
        end
    end

    // Frame position next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HEAD: begin
                if (push_s && !s_axis_tlast) state_d = ST_BODY;
                else                         state_d = ST_HEAD;
            end
            ST_BODY: begin
                if (push_s && s_axis_tlast) state_d = ST_HEAD;
                else                        state_d = ST_BODY;
            end
            default: state_d = ST_HEAD;
        endcase
    end

    // Skid buffer pointer/occupancy next-state
    always_comb begin
        rd_ptr_d = pop_s ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d = push_s ? ~wr_ptr_q : wr_ptr_q;
        if (push_s && !pop_s)      cnt_d = cnt_q + 2'd1;
        else if (!push_s && pop_s) cnt_d = cnt_q - 2'd1;
        else                       cnt_d = cnt_q;
    end

    // Metadata slot and counters next-state; a drain and reload in one cycle leaves no bubble
    always_comb begin
        hdr_valid_d = hdr_valid_q;
        src_ip_d    = src_ip_q;
        dst_ip_d    = dst_ip_q;
        proto_d     = proto_q;
        src_port_d  = src_port_q;
        dst_port_d  = dst_port_q;
        is_udp_d    = is_udp_q;
        error_d     = error_q;
        frames_d    = frames_q;
        errors_d    = errors_q;
        if (hdr_load_s) begin
            hdr_valid_d = 1'b1;
            src_ip_d    = p_src_ip_s;
            dst_ip_d    = p_dst_ip_s;
            proto_d     = p_proto_s;
            src_port_d  = p_src_port_s;
            dst_port_d  = p_dst_port_s;
            is_udp_d    = p_udp_s;
            error_d     = p_err_s;
            frames_d    = frames_q + 32'd1;
            errors_d    = p_err_s ? errors_q + 32'd1 : errors_q;
        end else if (hdr_drain_s) begin
            hdr_valid_d = 1'b0;
        end else begin
            hdr_valid_d = hdr_valid_q;
        end
    end

    // Control, metadata and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HEAD;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            rdy_en_q    <= 1'b0;
            hdr_valid_q <= 1'b0;
            src_ip_q    <= 32'h0000_0000;
            dst_ip_q    <= 32'h0000_0000;
            proto_q     <= 8'h00;
            src_port_q  <= 16'h0000;
            dst_port_q  <= 16'h0000;
            is_udp_q    <= 1'b0;
            error_q     <= 1'b0;
            frames_q    <= 32'h0000_0000;
            errors_q    <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            rdy_en_q    <= 1'b1;
            hdr_valid_q <= hdr_valid_d;
            src_ip_q    <= src_ip_d;
            dst_ip_q    <= dst_ip_d;
            proto_q     <= proto_d;
            src_port_q  <= src_port_d;
            dst_port_q  <= dst_port_d;
            is_udp_q    <= is_udp_d;
            error_q     <= error_d;
            frames_q    <= frames_d;
            errors_q    <= errors_d;
        end
    end

    // Skid buffer storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= in_beat_s;
        end
    end

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = mem_q[rd_ptr_q];
    assign m_axis_tvalid  = (cnt_q != 2'd0);
    assign m_hdr_valid    = hdr_valid_q;
    assign m_hdr_src_ip   = src_ip_q;
    assign m_hdr_dst_ip   = dst_ip_q;
    assign m_hdr_protocol = proto_q;
    assign m_hdr_src_port = src_port_q;
    assign m_hdr_dst_port = dst_port_q;
    assign m_hdr_is_udp   = is_udp_q;
    assign m_hdr_error    = error_q;
    assign stat_frames    = frames_q;
    assign stat_errors    = errors_q;

endmodule

// File: doc/rmt_ipv4_udp_parser.md
Name: rmt_ipv4_udp_parser

Overview:
- Sits directly downstream of the IPv4 ethertype filter stage on the same AXI-Stream port.
- Forwards each frame unchanged with one registered stage and full throughput.
- On each frame's first beat, extracts IPv4/UDP header fields into a separate metadata channel with its own valid/ready handshake.
- Later match-action stages use the metadata.

Parameters:
- DATA_WIDTH, 512: stream width in bits; must be ≥336 so Eth+IPv4+UDP (42 bytes) fit in beat 0.
- KEEP_WIDTH, DATA_WIDTH/8: byte-enable width.
- USER_WIDTH, 8: tuser width, passed through unchanged.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  input data; byte 0 in bits [7:0].
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of frame.
- s_axis_tuser  in  USER_WIDTH  sideband.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  as s_axis  forwarded stream.
- m_hdr_valid  out  1  metadata valid.
- m_hdr_ready  in  1  metadata ready.
- m_hdr_src_ip  out  32  IPv4 source address, host order.
- m_hdr_dst_ip  out  32  IPv4 destination address, host order.
- m_hdr_protocol  out  8  IPv4 protocol.
- m_hdr_src_port  out  16  UDP source port, host order; 0 if not UDP.
- m_hdr_dst_port  out  16  UDP destination port, host order; 0 if not UDP.
- m_hdr_is_udp  out  1  protocol==17, IHL==5, and not a fragment (MF=0, offset=0).
- m_hdr_error  out  1  version≠4, IHL≠5, or header truncated.
- stat_frames  out  32  count of frames whose first beat was accepted.
- stat_errors  out  32  count of frames with m_hdr_error=1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all valids 0, s_axis_tready 0, counters 0, state HEAD, skid buffer empty, metadata fields 0.
  - s_axis_tready may rise the first cycle after deassertion.
  - Reset mid-frame discards the partial frame. The next accepted beat is treated as a first beat.
- Network byte order: multi-byte field at byte offset k is {byte k, byte k+1, ...}. Example: ethertype bytes 12,13 = 08,00 → 0x0800.
- Header offsets: version/IHL byte 14; flags/fragment offset bytes 20-21; protocol byte 23; src_ip bytes 26-29; dst_ip bytes 30-33; UDP src_port bytes 34-35; UDP dst_port bytes 36-37.
- Truncation: if any tkeep bit for bytes 0..37 is 0 on beat 0, then m_hdr_error=1, m_hdr_is_udp=0, all address/port fields 0.
- State machine:
  - HEAD: on an accepted beat, capture metadata. If tlast=0 go to BODY; if tlast=1 stay in HEAD.
  - BODY: on an accepted beat with tlast=1 go to HEAD.
- Data path:
  - 2-entry skid buffer; accept-to-m_axis_tvalid latency 1 cycle.
  - Sustains 1 beat/cycle while m_axis_tready=1.
  - Output order preserved; tdata/tkeep/tlast/tuser bit-exact.
- Metadata:
  - Single register slot. m_hdr_valid rises in the same cycle the frame's first beat appears on m_axis.
  - Holds until m_hdr_valid && m_hdr_ready.
  - Fields stable while valid and not yet accepted.
- s_axis_tready = skid buffer not full AND (state==BODY OR metadata slot empty OR slot being drained this cycle).
  - Consequence: a new frame's first beat stalls while the previous frame's metadata is unconsumed.
  - Body beats never stall on metadata.
- Counters:
  - stat_frames increments by 1 on each accepted first beat.
  - stat_errors increments by 1 on each accepted first beat with error=1.
  - Both wrap 0xFFFFFFFF→0 without saturation.
- Simultaneous metadata drain and new first beat in one cycle: the slot is reloaded with no bubble.

Test Plan:
- UDP frame, 3 beats, src 10.0.0.1, dst 192.168.1.2, ports 0x1234→0x0050, m_hdr_ready=1 → m_hdr_src_ip=0x0A000001, dst_ip=0xC0A80102, src_port=0x1234, dst_port=0x0050, is_udp=1, error=0; data out bit-exact, 1 cycle latency; stat_frames=1.
- TCP frame (protocol 6) → is_udp=0, ports 0, error=0, protocol=0x06.
- IHL=6 header, and separately a single-beat frame with tkeep covering 30 bytes → error=1, is_udp=0 for both; stat_errors=2.
- m_axis_tready toggling 1010… over a 5-beat frame → no beat lost or duplicated, tlast on beat 5 only.
- m_hdr_ready=0 with two back-to-back frames → frame 1 fully forwarded; frame 2 beat 0 stalled (s_axis_tready=0) until m_hdr_ready=1, then proceeds with 0 bubble.
- Assert rst_n=0 during beat 2 of 4 → all outputs 0 immediately; next frame parsed correctly from its first beat.
